spi_master_shifter: RTL

Byte-serial SPI master engine directly downstream of `spi_master_fifo`: pops bytes from the transmit FIFO and shifts them out on SCLK/MOSI under SS. It captures MISO into receive bytes, supporting all four CPOL/CPHA modes and MSB/LSB order. Back-to-back bytes run with a continuous SCLK and SS held low. It is the last stage before the SPI pads in the master datapath.

---
 rtl/spi_master_shifter_pkg.sv | 32 +++
 rtl/spi_master_shifter_clkgen.sv | 54 +++++
 rtl/spi_master_shifter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_master_shifter_pkg.sv
// rtl/spi_master_shifter_pkg.sv - shared types and bit-order helpers for the SPI master shifter
// Contents: FSM state encoding, serial byte width, and MSB/LSB-order shift helpers.

package spi_master_shifter_pkg;

   localparam int SPI_SW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_e;

   // Bit presented on MOSI from a shift register in the given order.
   function automatic logic first_bit(input logic [SPI_SW-1:0] sr, input logic lsb);
      return lsb ? sr[0] : sr[SPI_SW-1];
   endfunction

   // Drop the bit just sent so the next one sits in the output position.
   function automatic logic [SPI_SW-1:0] tx_advance(input logic [SPI_SW-1:0] sr, input logic lsb);
      return lsb ? {1'b0, sr[SPI_SW-1:1]} : {sr[SPI_SW-2:0], 1'b0};
   endfunction

   // Insert a received bit so that after SPI_SW inserts the first bit lands
   // in bit 0 (LSB-first) or bit SPI_SW-1 (MSB-first).
   function automatic logic [SPI_SW-1:0] rx_insert(input logic [SPI_SW-1:0] sr, input logic din,
                                                   input logic lsb);
      return lsb ? {din, sr[SPI_SW-1:1]} : {sr[SPI_SW-2:0], din};
   endfunction

endpackage

// File: rtl/spi_master_shifter_clkgen.sv
// rtl/spi_master_shifter_clkgen.sv - SCLK divider, edge counter and leading/trailing strobes
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   run                  divider runs while high, cleared while low
//   edge_en              divider terminal counts become SCLK edges
//   clkdiv               half-period minus one, in clk cycles
//   tick                 divider terminal count
//   edge_stb             tick that toggles SCLK
//   lead_stb, trail_stb  edge_stb split into odd (leading) / even (trailing) edges
//   first_edge           next edge is edge 1 of the byte
//   last_edge            next edge is edge 16 of the byte

module spi_master_shifter_clkgen #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          run,
   input  logic          edge_en,
   input  logic [DW-1:0] clkdiv,
   output logic          tick,
   output logic          edge_stb,
   output logic          lead_stb,
   output logic          trail_stb,
   output logic          first_edge,
   output logic          last_edge
);

   logic [DW-1:0] div_cnt;
   logic [3:0]    edge_idx;   // edges already issued in this byte, wraps after 16

   assign tick       = run & (div_cnt == clkdiv);
   assign edge_stb   = tick & edge_en;
   assign lead_stb   = edge_stb & ~edge_idx[0];
   assign trail_stb  = edge_stb &  edge_idx[0];
   assign first_edge = (edge_idx == 4'd0);
   assign last_edge  = (edge_idx == 4'd15);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         div_cnt  <= '0;
         edge_idx <= 4'd0;
      end else if (!run) begin
         div_cnt  <= '0;
         edge_idx <= 4'd0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (edge_stb) begin
            edge_idx <= edge_idx + 4'd1;
         end
      end
   end

endmodule

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - byte-serial SPI master engine fed from a show-ahead TX FIFO
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   spi_en                      allows new bytes to be popped
//   cpol, cpha, lsbfirst        SPI mode and bit order, latched per burst
//   clkdiv                      SCLK half-period = clkdiv+1 clk cycles, latched per burst
//   fifo_empty, fifo_dout       TX FIFO status and head byte
//   fifo_read                   one-cycle pop
//   sclk, mosi, ss              SPI pins (ss active low), registered
//   miso                        SPI serial input
//   rx_access, rx_data          received-byte strobe and held byte
//   spi_busy                    transfer in progress

module spi_master_shifter
   import spi_master_shifter_pkg::*;
#(
   parameter int SW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          spi_en,
   input  logic          cpol,
   input  logic          cpha,
   input  logic          lsbfirst,
   input  logic [DW-1:0] clkdiv,
   input  logic          fifo_empty,
   input  logic [SW-1:0] fifo_dout,
   output logic          fifo_read,
   output logic          sclk,
   output logic          mosi,
   output logic          ss,
   input  logic          miso,
   output logic          rx_access,
   output logic [SW-1:0] rx_data,
   output logic          spi_busy
);

   spi_state_e    state, state_nxt;
   logic          run_ok;       // keeps fifo_read low while nreset is held
   logic          cpol_q, cpha_q, lsb_q;
   logic [DW-1:0] clkdiv_q;
   logic [SW-1:0] tx_sr, rx_sr, tx_adv, rx_next;
   logic          tick, edge_stb, lead_stb, trail_stb, first_edge, last_edge;
   logic          start, byte_done, reload, capture, advance;

   spi_master_shifter_clkgen #(.DW(DW)) u_clkgen (
      .clk        (clk),
      .nreset     (nreset),
      .run        (state != ST_IDLE),
      .edge_en    ((state == ST_SETUP) || (state == ST_SHIFT)),
      .clkdiv     (clkdiv_q),
      .tick       (tick),
      .edge_stb   (edge_stb),
      .lead_stb   (lead_stb),
      .trail_stb  (trail_stb),
      .first_edge (first_edge),
      .last_edge  (last_edge)
   );

   assign start     = (state == ST_IDLE) & run_ok & spi_en & ~fifo_empty;
   assign byte_done = (state == ST_SHIFT) & edge_stb & last_edge;
   assign reload    = byte_done & spi_en & ~fifo_empty;

   // cpha=0 samples on leading edges and shifts on trailing ones (not edge 16,
   // which ends the byte); cpha=1 is the mirror, skipping edge 1 because the
   // first bit was already placed during SETUP.
   assign capture = cpha_q ? trail_stb : lead_stb;
   assign advance = cpha_q ? (lead_stb & ~first_edge) : (trail_stb & ~last_edge);
   assign tx_adv  = tx_advance(tx_sr, lsb_q);
   assign rx_next = rx_insert(rx_sr, miso, lsb_q);

   assign spi_busy = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      fifo_read = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               fifo_read = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (reload) begin
               fifo_read = 1'b1;
            end else if (byte_done) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // ss has already risen; one cycle with ss high before the next pop
            if (ss) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= ST_IDLE;
         run_ok    <= 1'b0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         clkdiv_q  <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         ss        <= 1'b1;
         rx_access <= 1'b0;
         rx_data   <= '0;
      end else begin
         state     <= state_nxt;
         run_ok    <= 1'b1;
         rx_access <= 1'b0;
         case (state)
            ST_IDLE: begin
               ss   <= 1'b1;
               sclk <= cpol;
               mosi <= 1'b0;
               if (start) begin
                  cpol_q   <= cpol;
                  cpha_q   <= cpha;
                  lsb_q    <= lsbfirst;
                  clkdiv_q <= clkdiv;
                  tx_sr    <= fifo_dout;
                  mosi     <= first_bit(fifo_dout, lsbfirst);
                  ss       <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (tick && !ss) begin
                  ss   <= 1'b1;
                  sclk <= cpol_q;
               end
            end
            default: begin
               if (edge_stb) sclk <= ~sclk;
               if (capture)  rx_sr <= rx_next;
               if (advance) begin
                  tx_sr <= tx_adv;
                  mosi  <= first_bit(tx_adv, lsb_q);
               end
               if (byte_done) begin
                  rx_access <= 1'b1;
                  rx_data   <= capture ? rx_next : rx_sr;
               end
               if (reload) begin
                  tx_sr <= fifo_dout;
                  mosi  <= first_bit(fifo_dout, lsb_q);
               end
            end
         endcase
      end
   end

endmodule
